// File: rtl/multdiv_div.sv
// multdiv_div: multi-cycle signed restoring divider, one quotient bit per cycle.
//   clock            in   rising-edge clock
//   reset_n          in   asynchronous active-low reset
//   ctrl_DIV         in   start pulse; operands sampled on this cycle
//   data_operandA    in   WIDTH dividend (two's complement)
//   data_operandB    in   WIDTH divisor (two's complement)
//   data_result      out  WIDTH signed quotient, truncated toward zero
//   data_exception   out  divide-by-zero / overflow flag
//   data_resultRDY   out  one-cycle result-valid pulse
//   data_remainder   out  WIDTH signed remainder (only with MULTDIV_DIV_REMAINDER_EN)
// Optional feature macro: MULTDIV_DIV_REMAINDER_EN
module multdiv_div #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY
`ifdef MULTDIV_DIV_REMAINDER_EN
    ,
    output logic [WIDTH-1:0] data_remainder
`endif
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             qsign_q, qsign_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             exc_q, exc_d;
`ifdef MULTDIV_DIV_REMAINDER_EN
    logic             rsign_q, rsign_d;
    logic [WIDTH-1:0] remout_q, remout_d;
`endif

    logic [WIDTH:0]   shifted, diff;
    logic             q_bit;
    logic [WIDTH-1:0] rem_next, quo_next, a_abs, b_abs;

    // The running remainder always stays below the divisor magnitude, so it
    // fits in WIDTH bits; only the trial shift/subtract needs the extra bit.
    // quo_q starts as |dividend| and fills with quotient bits from the right.
    assign shifted  = {rem_q, quo_q[WIDTH-1]};
    assign diff     = shifted - {1'b0, div_q};
    assign q_bit    = ~diff[WIDTH];
    assign rem_next = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    assign quo_next = {quo_q[WIDTH-2:0], q_bit};
    assign a_abs    = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    assign b_abs    = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        quo_d    = quo_q;
        div_d    = div_q;
        rem_d    = rem_q;
        qsign_d  = qsign_q;
        result_d = result_q;
        exc_d    = exc_q;
`ifdef MULTDIV_DIV_REMAINDER_EN
        rsign_d  = rsign_q;
        remout_d = remout_q;
`endif
        if (ctrl_DIV) begin
            cnt_d = '0;
            exc_d = 1'b0;
            if (data_operandB == '0) begin
                state_d  = DONE;
                exc_d    = 1'b1;
                result_d = '0;
`ifdef MULTDIV_DIV_REMAINDER_EN
                remout_d = '0;
`endif
            end else if (data_operandA == MIN_VAL && data_operandB == '1) begin
                state_d  = DONE;
                exc_d    = 1'b1;
                result_d = MIN_VAL;
`ifdef MULTDIV_DIV_REMAINDER_EN
                remout_d = '0;
`endif
            end else begin
                state_d = RUN;
                quo_d   = a_abs;
                div_d   = b_abs;
                rem_d   = '0;
                qsign_d = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
`ifdef MULTDIV_DIV_REMAINDER_EN
                rsign_d = data_operandA[WIDTH-1];
`endif
            end
        end else if (state_q == RUN) begin
            quo_d = quo_next;
            rem_d = rem_next;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
                state_d  = DONE;
                result_d = qsign_q ? -quo_next : quo_next;
`ifdef MULTDIV_DIV_REMAINDER_EN
                remout_d = rsign_q ? -rem_next : rem_next;
`endif
            end
        end else if (state_q != IDLE) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            quo_q    <= '0;
            div_q    <= '0;
            rem_q    <= '0;
            qsign_q  <= 1'b0;
            result_q <= '0;
            exc_q    <= 1'b0;
`ifdef MULTDIV_DIV_REMAINDER_EN
            rsign_q  <= 1'b0;
            remout_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            quo_q    <= quo_d;
            div_q    <= div_d;
            rem_q    <= rem_d;
            qsign_q  <= qsign_d;
            result_q <= result_d;
            exc_q    <= exc_d;
`ifdef MULTDIV_DIV_REMAINDER_EN
            rsign_q  <= rsign_d;
            remout_q <= remout_d;
`endif
        end
    end

    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = (state_q == DONE);
`ifdef MULTDIV_DIV_REMAINDER_EN
    assign data_remainder = remout_q;
`endif
endmodule
